// File: rtl/csr_pkg.sv
// Shared CSR constants for the machine-mode interrupt controller:
// mip bit positions, interrupt exception codes, the mcause interrupt flag
// and the request FSM state encoding.
package csr_pkg;

   // mip / mie bit positions
   localparam int unsigned MIP_MSIP = 3;
   localparam int unsigned MIP_MTIP = 7;
   localparam int unsigned MIP_MEIP = 11;

   // Interrupt exception codes (equal to the matching mip bit index)
   localparam logic [63:0] EXC_MSI = 64'd3;
   localparam logic [63:0] EXC_MTI = 64'd7;
   localparam logic [63:0] EXC_MEI = 64'd11;

   // mcause bit 63 marks an interrupt
   localparam logic [63:0] MCAUSE_INT = 64'h8000_0000_0000_0000;

   typedef enum logic [1:0] {
      IRQ_IDLE    = 2'd0,
      IRQ_REQ     = 2'd1,
      IRQ_HOLDOFF = 2'd2
   } irq_state_e;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchronizer for asynchronous level inputs.
module irq_sync #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [DEPTH-1:0][WIDTH-1:0] sync_q;

   // Shift the raw level through DEPTH flops; stage 0 takes the raw input
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[DEPTH-2:0], d_i};
      end
   end

   assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: synchronizes the timer, software and
// external interrupt lines, builds mip, and raises a prioritized request
// with a captured mcause, followed by a hold-off window after acknowledge.
module irq_ctrl
   import csr_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned HOLDOFF_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        trint,
   input  logic        swint,
   input  logic        exint,
   input  logic        mstatus_mie,
   input  logic [63:0] mie,
   input  logic        irq_ack,
   output logic [63:0] mip_out,
   output logic        irq_req,
   output logic [63:0] irq_cause
);

   logic        mtip_s, msip_s, meip_s;
   logic [63:0] mip;
   logic [63:0] elig;
   logic [63:0] sel_cause;
   logic        cause_still_elig;

   irq_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] cause_q, cause_d;

   irq_sync #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_sync_mti (
      .clk   (clk),
      .reset (reset),
      .d_i   (trint),
      .q_o   (mtip_s)
   );

   irq_sync #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_sync_msi (
      .clk   (clk),
      .reset (reset),
      .d_i   (swint),
      .q_o   (msip_s)
   );

   irq_sync #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_sync_mei (
      .clk   (clk),
      .reset (reset),
      .d_i   (exint),
      .q_o   (meip_s)
   );

   // Assemble mip and pick the highest-priority eligible cause (MEI > MSI > MTI)
   always_comb begin
      mip           = '0;
      mip[MIP_MTIP] = mtip_s;
      mip[MIP_MSIP] = msip_s;
      mip[MIP_MEIP] = meip_s;
      elig          = mip & mie & {64{mstatus_mie}};
      if (elig[MIP_MEIP]) begin
         sel_cause = MCAUSE_INT | EXC_MEI;
      end else if (elig[MIP_MSIP]) begin
         sel_cause = MCAUSE_INT | EXC_MSI;
      end else begin
         sel_cause = MCAUSE_INT | EXC_MTI;
      end
      // exception code doubles as the mip/mie bit index
      cause_still_elig = elig[cause_q[5:0]];
   end

   // State, hold-off counter and captured cause registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IRQ_IDLE;
         cnt_q   <= '0;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
      end
   end

   // Next-state logic; cause is cleared on every exit from REQ so it reads zero outside REQ
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      case (state_q)
         IRQ_IDLE: begin
            if (|elig) begin
               state_d = IRQ_REQ;
               cause_d = sel_cause;
            end
         end
         IRQ_REQ: begin
            if (irq_ack) begin
               state_d = IRQ_HOLDOFF;
               cnt_d   = 4'(HOLDOFF_CYCLES - 1);
               cause_d = '0;
            end else if (!cause_still_elig) begin
               state_d = IRQ_IDLE;
               cause_d = '0;
            end
         end
         IRQ_HOLDOFF: begin
            if (cnt_q == 4'd0) begin
               state_d = IRQ_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = IRQ_IDLE;
            cause_d = '0;
         end
      endcase
   end

   assign mip_out   = mip;
   assign irq_req   = (state_q == IRQ_REQ);
   assign irq_cause = cause_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: a table of static interrupt patterns
// plus hand-written multi-cycle sequences (latency, ack/hold-off,
// no-upgrade, retraction, ack-vs-retraction, reset mid-request).
module tb_irq_ctrl;

   localparam int unsigned SS = 2;
   localparam int unsigned HO = 3;

   localparam logic [63:0] C_MSI = 64'h8000_0000_0000_0003;
   localparam logic [63:0] C_MTI = 64'h8000_0000_0000_0007;
   localparam logic [63:0] C_MEI = 64'h8000_0000_0000_000B;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        trint = 1'b0;
   logic        swint = 1'b0;
   logic        exint = 1'b0;
   logic        mstatus_mie = 1'b0;
   logic [63:0] mie = '0;
   logic        irq_ack = 1'b0;
   logic [63:0] mip_out;
   logic        irq_req;
   logic [63:0] irq_cause;

   int checks = 0;
   int errors = 0;

   irq_ctrl #(.SYNC_STAGES(SS), .HOLDOFF_CYCLES(HO)) dut (
      .clk         (clk),
      .reset       (reset),
      .trint       (trint),
      .swint       (swint),
      .exint       (exint),
      .mstatus_mie (mstatus_mie),
      .mie         (mie),
      .irq_ack     (irq_ack),
      .mip_out     (mip_out),
      .irq_req     (irq_req),
      .irq_cause   (irq_cause)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        tr, sw, ex, gmie;
      logic [63:0] mie;
      logic [63:0] exp_mip;
      logic        exp_req;
      logic [63:0] exp_cause;
   } vec_t;

   vec_t vecs[10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic [63:0] emip,
                          input logic ereq, input logic [63:0] ecause);
      chk({name, ".mip"},   mip_out,          emip);
      chk({name, ".req"},   {63'd0, irq_req}, {63'd0, ereq});
      chk({name, ".cause"}, irq_cause,        ecause);
   endtask

   task automatic do_reset();
      irq_ack = 1'b0;
      trint = 1'b0; swint = 1'b0; exint = 1'b0;
      mstatus_mie = 1'b0; mie = '0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1, 0, 0, 1, 64'h080, 64'h080, 1, C_MTI};
      vecs[1] = '{0, 1, 0, 1, 64'h008, 64'h008, 1, C_MSI};
      vecs[2] = '{0, 0, 1, 1, 64'h800, 64'h800, 1, C_MEI};
      vecs[3] = '{1, 1, 1, 1, 64'h888, 64'h888, 1, C_MEI};
      vecs[4] = '{1, 1, 0, 1, 64'h888, 64'h088, 1, C_MSI};
      vecs[5] = '{1, 1, 1, 1, 64'h088, 64'h888, 1, C_MSI};
      vecs[6] = '{1, 1, 1, 0, 64'h888, 64'h888, 0, 64'd0};
      vecs[7] = '{1, 1, 1, 1, 64'h000, 64'h888, 0, 64'd0};
      vecs[8] = '{0, 0, 0, 1, '1,      64'h000, 0, 64'd0};
      vecs[9] = '{1, 0, 0, 1, ~64'h080, 64'h080, 0, 64'd0};

      // Reset state, observed while reset is held
      reset = 1'b1;
      trint = 1'b1; swint = 1'b1; exint = 1'b1;
      mstatus_mie = 1'b1; mie = '1;
      tick(); tick(); tick();
      chk_out("reset_hold", 64'd0, 1'b0, 64'd0);

      // Table: static patterns from IDLE, checked SS+1 edges after the lines rise
      for (int i = 0; i < 10; i++) begin
         do_reset();
         trint = vecs[i].tr; swint = vecs[i].sw; exint = vecs[i].ex;
         mstatus_mie = vecs[i].gmie; mie = vecs[i].mie;
         for (int unsigned k = 0; k < SS + 1; k++) tick();
         chk_out($sformatf("vec%0d", i), vecs[i].exp_mip, vecs[i].exp_req, vecs[i].exp_cause);
      end

      // Basic timer: latency to mip and to irq_req, then ack and hold-off
      do_reset();
      mie = 64'h080; mstatus_mie = 1'b1; trint = 1'b1;
      for (int unsigned k = 1; k < SS; k++) begin
         tick();
         chk("lat.mip_early", mip_out, 64'd0);
      end
      tick();
      chk("lat.mip", mip_out, 64'h080);
      chk("lat.req_early", {63'd0, irq_req}, 64'd0);
      tick();
      chk_out("lat.req", 64'h080, 1'b1, C_MTI);
      tick();
      chk_out("lat.hold", 64'h080, 1'b1, C_MTI);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk_out("ack.holdoff0", 64'h080, 1'b0, 64'd0);
      for (int unsigned k = 1; k < HO + 1; k++) begin
         tick();
         chk_out($sformatf("ack.gap%0d", k), 64'h080, 1'b0, 64'd0);
      end
      tick();
      chk_out("ack.rereq", 64'h080, 1'b1, C_MTI);

      // No upgrade while in REQ
      do_reset();
      mie = 64'h888; mstatus_mie = 1'b1; swint = 1'b1;
      for (int unsigned k = 0; k < SS + 1; k++) tick();
      chk_out("noupg.req", 64'h008, 1'b1, C_MSI);
      exint = 1'b1;
      for (int unsigned k = 0; k < SS + 2; k++) tick();
      chk_out("noupg.stay", 64'h808, 1'b1, C_MSI);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk_out("noupg.ack", 64'h808, 1'b0, 64'd0);
      for (int unsigned k = 0; k < HO; k++) tick();
      chk("noupg.idle", {63'd0, irq_req}, 64'd0);
      tick();
      chk_out("noupg.next", 64'h808, 1'b1, C_MEI);

      // Retraction: global enable drops without ack
      do_reset();
      mie = 64'h080; mstatus_mie = 1'b1; trint = 1'b1;
      for (int unsigned k = 0; k < SS + 1; k++) tick();
      chk("retr.req", {63'd0, irq_req}, 64'd1);
      mstatus_mie = 1'b0;
      tick();
      chk_out("retr.drop", 64'h080, 1'b0, 64'd0);
      tick();
      chk("retr.stay", {63'd0, irq_req}, 64'd0);
      mstatus_mie = 1'b1;
      tick();
      chk_out("retr.idle_rereq", 64'h080, 1'b1, C_MTI);

      // Retraction via mie of the captured bit only (other cause still pending)
      do_reset();
      mie = 64'h088; mstatus_mie = 1'b1; trint = 1'b1; swint = 1'b1;
      for (int unsigned k = 0; k < SS + 1; k++) tick();
      chk("retr2.req", irq_cause, C_MSI);
      mie = 64'h080;
      tick();
      chk_out("retr2.drop", 64'h088, 1'b0, 64'd0);
      tick();
      chk_out("retr2.mti", 64'h088, 1'b1, C_MTI);

      // Ack and retraction in the same cycle: ack wins, full hold-off, ack ignored there
      do_reset();
      mie = 64'h080; mstatus_mie = 1'b1; trint = 1'b1;
      for (int unsigned k = 0; k < SS + 1; k++) tick();
      chk("both.req", {63'd0, irq_req}, 64'd1);
      irq_ack = 1'b1; mstatus_mie = 1'b0;
      tick();
      mstatus_mie = 1'b1;
      chk_out("both.ho0", 64'h080, 1'b0, 64'd0);
      for (int unsigned k = 1; k < HO; k++) begin
         tick();
         chk_out($sformatf("both.ho%0d", k), 64'h080, 1'b0, 64'd0);
      end
      irq_ack = 1'b0;
      tick();
      chk("both.idle", {63'd0, irq_req}, 64'd0);
      tick();
      chk_out("both.rereq", 64'h080, 1'b1, C_MTI);

      // Reset in the middle of REQ with exint held high
      do_reset();
      mie = 64'h800; mstatus_mie = 1'b1; exint = 1'b1;
      for (int unsigned k = 0; k < SS + 1; k++) tick();
      chk("rst.req", {63'd0, irq_req}, 64'd1);
      irq_ack = 1'b1;
      #1 reset = 1'b1;
      #1 chk_out("rst.async", 64'd0, 1'b0, 64'd0);
      tick();
      chk_out("rst.held", 64'd0, 1'b0, 64'd0);
      irq_ack = 1'b0;
      reset = 1'b0;
      for (int unsigned k = 1; k < SS; k++) begin
         tick();
         chk("rst.mip_early", mip_out, 64'd0);
      end
      tick();
      chk_out("rst.mip", 64'h800, 1'b0, 64'd0);
      tick();
      chk_out("rst.rereq", 64'h800, 1'b1, C_MEI);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
